// File: rtl/ring_buffer_word_assembler.sv
// Pulls bytes from the ring buffer read port and packs them little-endian into words.
// Optional partial-word flush after repeated empty reads: define RB_ASM_TIMEOUT_EN.
module ring_buffer_word_assembler #(
  parameter int WordSize     = 8,
  parameter int BytesPerWord = 4,
  parameter int CountBits    = 3,
  parameter int TimeoutLimit = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             dataReadEnable,
  input  logic                             dataReadAck,
  input  logic [WordSize-1:0]              dataRead,
  output logic                             wordValid,
  input  logic                             wordReady,
  output logic [WordSize*BytesPerWord-1:0] wordData,
  output logic [CountBits-1:0]             wordBytes
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [CountBits-1:0] FullCount = CountBits'(BytesPerWord);

  state_t                                 state_q;
  logic                                   rd_en_q;
  logic                                   valid_q;
  logic [CountBits-1:0]                   bytes_q;
  logic [CountBits-1:0]                   count_q;
  logic [BytesPerWord-1:0][WordSize-1:0]  lanes_q;

  logic [CountBits-1:0] count_d;
  logic                 capture_d;
  logic                 release_d;

  assign count_d   = count_q + 1'b1;
  assign capture_d = (state_q == S_CHECK) && dataReadAck;
  assign release_d = (state_q == S_OUT) && wordReady;

`ifdef RB_ASM_TIMEOUT_EN
  localparam int RetryBits = $clog2(TimeoutLimit + 1);

  logic [RetryBits-1:0] retry_q;
  logic                 expire_d;

  // A word that has not started yet is never flushed, however long the buffer stays empty.
  assign expire_d = (count_q != '0) && ((32'(retry_q) + 32'd1) == 32'(TimeoutLimit));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      bytes_q <= '0;
      count_q <= '0;
`ifdef RB_ASM_TIMEOUT_EN
      retry_q <= '0;
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          rd_en_q <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          rd_en_q <= 1'b0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (dataReadAck) begin
            count_q <= count_d;
`ifdef RB_ASM_TIMEOUT_EN
            retry_q <= '0;
`endif
            if (count_d == FullCount) begin
              valid_q <= 1'b1;
              bytes_q <= FullCount;
              state_q <= S_OUT;
            end else begin
              state_q <= S_REQ;
            end
          end else begin
`ifdef RB_ASM_TIMEOUT_EN
            if (expire_d) begin
              valid_q <= 1'b1;
              bytes_q <= count_q;
              retry_q <= '0;
              state_q <= S_OUT;
            end else begin
              if (retry_q != '1) begin
                retry_q <= retry_q + 1'b1;
              end
              state_q <= S_REQ;
            end
`else
            state_q <= S_REQ;
`endif
          end
        end
        S_OUT: begin
          // No read is issued here, so a stalled consumer holds the ring buffer back.
          if (wordReady) begin
            valid_q <= 1'b0;
            bytes_q <= '0;
            count_q <= '0;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BytesPerWord; gi++) begin : g_lane
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lanes_q[gi] <= '0;
        end else if (release_d) begin
          lanes_q[gi] <= '0;
        end else if (capture_d && (count_q == CountBits'(gi))) begin
          lanes_q[gi] <= dataRead;
        end
      end
    end
  endgenerate

  assign dataReadEnable = rd_en_q;
  assign wordValid      = valid_q;
  assign wordBytes      = bytes_q;
  assign wordData       = lanes_q;

endmodule

// File: tb/tb_ring_buffer_word_assembler.sv
// Bench for ring_buffer_word_assembler: a queue-based ring buffer and word scoreboard drive
// directed and random traffic. Define RB_ASM_TIMEOUT_EN to exercise the partial flush.
module tb_ring_buffer_word_assembler;

  localparam int WS  = 8;
  localparam int BPW = 4;
  localparam int CB  = 3;
  localparam int TL  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dataReadEnable;
  logic          dataReadAck = 1'b0;
  logic [WS-1:0] dataRead = '0;
  logic          wordValid;
  logic          wordReady = 1'b0;
  logic [WS*BPW-1:0] wordData;
  logic [CB-1:0] wordBytes;

  ring_buffer_word_assembler #(
    .WordSize(WS), .BytesPerWord(BPW), .CountBits(CB), .TimeoutLimit(TL)
  ) dut (
    .clk(clk), .reset(reset),
    .dataReadEnable(dataReadEnable), .dataReadAck(dataReadAck), .dataRead(dataRead),
    .wordValid(wordValid), .wordReady(wordReady),
    .wordData(wordData), .wordBytes(wordBytes)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Ring buffer contents and the scoreboard's view of the word being assembled.
  logic [WS-1:0] rb_q[$];
  logic [WS-1:0] exp_bytes[$];
  logic          exp_valid = 1'b0;
  logic          resp_pending = 1'b0;
  logic          resp_ack = 1'b0;
  logic [WS-1:0] resp_data = '0;
  int            fail_cnt = 0;
  int            reqs = 0;
  int            cyc = 0;
  int            last_req = -100;
  int            last_gap = 0;
  logic          new_req = 1'b0;
  logic          chk_en = 1'b0;
  int            words_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WS*BPW-1:0] pack_exp();
    logic [WS*BPW-1:0] w;
    w = '0;
    for (int i = 0; i < exp_bytes.size(); i++) w[i*WS +: WS] = exp_bytes[i];
    return w;
  endfunction

  task automatic tick();
    logic en_e;
    logic acc;
    logic valid_pre;
    en_e      = dataReadEnable;
    valid_pre = exp_valid;
    acc       = exp_valid && wordReady;
    @(posedge clk);
    #1;
    cyc++;
    new_req = 1'b0;
    if (acc) begin
      exp_valid = 1'b0;
      exp_bytes.delete();
      words_acc++;
    end
    if (resp_pending) begin
      resp_pending = 1'b0;
      if (resp_ack) begin
        exp_bytes.push_back(resp_data);
        fail_cnt = 0;
        if (exp_bytes.size() == BPW) exp_valid = 1'b1;
      end else begin
        fail_cnt++;
`ifdef RB_ASM_TIMEOUT_EN
        if (exp_bytes.size() > 0 && fail_cnt == TL) exp_valid = 1'b1;
`endif
      end
    end
    if (en_e) begin
      reqs++;
      new_req  = 1'b1;
      last_gap = cyc - last_req;
      last_req = cyc;
      resp_pending = 1'b1;
      if (rb_q.size() > 0) begin
        resp_ack  = 1'b1;
        resp_data = rb_q.pop_front();
      end else begin
        resp_ack  = 1'b0;
        resp_data = WS'($urandom);
      end
      dataReadAck = resp_ack;
      dataRead    = resp_data;
    end
    if (chk_en) begin
      chk("valid", {63'd0, wordValid}, {63'd0, exp_valid});
      chk("lanes", 64'(wordData), 64'(pack_exp()));
      if (exp_valid) chk("wbytes", 64'(wordBytes), 64'(exp_bytes.size()));
      chk("req_while_valid", {63'd0, en_e & valid_pre}, 64'd0);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    dataReadAck = 1'($urandom);
    dataRead    = WS'($urandom);
    wordReady   = 1'($urandom);
    #1;
    chk("rst_async_data", 64'(wordData), 64'd0);
    chk("rst_async_valid", {63'd0, wordValid}, 64'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_en", {63'd0, dataReadEnable}, 64'd0);
      chk("rst_valid", {63'd0, wordValid}, 64'd0);
      chk("rst_data", 64'(wordData), 64'd0);
      chk("rst_bytes", 64'(wordBytes), 64'd0);
      dataReadAck = 1'($urandom);
      dataRead    = WS'($urandom);
      wordReady   = 1'($urandom);
    end
    dataReadAck  = 1'b0;
    wordReady    = 1'b0;
    exp_valid    = 1'b0;
    exp_bytes.delete();
    resp_pending = 1'b0;
    fail_cnt     = 0;
    reset        = 1'b1;
  endtask

  initial begin
    int n;
    logic [WS*BPW-1:0] held;

    // Reset with random inputs.
    do_reset(5);
    chk_en = 1'b1;

    // Full word from a pre-filled buffer.
    rb_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    wordReady = 1'b1;
    reqs = 0;
    n = 0;
    while (!wordValid && n < 40) begin
      tick();
      n++;
    end
    chk("t2_latency", 64'(n), 64'd12);
    chk("t2_reqs", 64'(reqs), 64'd4);
    chk("t2_data", 64'(wordData), 64'h44332211);
    chk("t2_bytes", 64'(wordBytes), 64'd4);
    tick();
    chk("t2_valid_one_cycle", {63'd0, wordValid}, 64'd0);

    // Empty buffer: a request every third cycle, nothing produced.
    reqs = 0;
    last_req = -100;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (new_req && reqs > 1) chk("t3_gap", 64'(last_gap), 64'd3);
    end
    chk("t3_reqs_ge9", {63'd0, reqs >= 9}, 64'd1);
    chk("t3_no_word", {63'd0, wordValid}, 64'd0);

    // Backpressure holds the word and stops reads.
    wordReady = 1'b0;
    rb_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    n = 0;
    while (!wordValid && n < 60) begin
      tick();
      n++;
    end
    chk("t4_valid", {63'd0, wordValid}, 64'd1);
    chk("t4_data", 64'(wordData), 64'hDDCCBBAA);
    held = wordData;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_hold", 64'(wordData), 64'(held));
    end
    chk("t4_no_reqs", 64'(reqs), 64'd0);
    wordReady = 1'b1;
    tick();
    chk("t4_accepted", {63'd0, wordValid}, 64'd0);
    n = 0;
    while (reqs == 0 && n < 6) begin
      tick();
      n++;
    end
    chk("t4_resume", {63'd0, reqs > 0}, 64'd1);

    // Reset after two of four bytes.
    chk_en = 1'b0;
    do_reset(2);
    chk_en = 1'b1;
    rb_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    n = 0;
    while (exp_bytes.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_two_captured", 64'(wordData), 64'h00000201);
    chk_en = 1'b0;
    do_reset(2);
    chk_en = 1'b1;
    rb_q.delete();
    rb_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    wordReady = 1'b1;
    n = 0;
    while (!wordValid && n < 40) begin
      tick();
      n++;
    end
    chk("t5_data", 64'(wordData), 64'h88776655);
    chk("t5_bytes", 64'(wordBytes), 64'd4);
    tick();

`ifdef RB_ASM_TIMEOUT_EN
    // Partial flush after TimeoutLimit failed reads.
    chk_en = 1'b0;
    do_reset(2);
    chk_en = 1'b1;
    wordReady = 1'b0;
    rb_q = '{8'hAA, 8'hBB};
    n = 0;
    while (!wordValid && n < 150) begin
      tick();
      n++;
    end
    chk("t6_data", 64'(wordData), 64'h0000BBAA);
    chk("t6_bytes", 64'(wordBytes), 64'd2);
    chk("t6_fails", 64'(fail_cnt), 64'(TL));
    wordReady = 1'b1;
    tick();
    chk("t6_accepted", {63'd0, wordValid}, 64'd0);
`endif

    // Random traffic against the scoreboard.
    words_acc = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && rb_q.size() < 16) rb_q.push_back(WS'($urandom));
      wordReady = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand_words", {63'd0, words_acc > 10}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
